// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: one Wishbone link. Address, control and write data travel
// from the master side; read data and ack/err come back from the slave side.
interface wb_arbiter_if;
    logic [31:0] addr;
    logic        cyc;
    logic [3:0]  stb;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output addr, cyc, stb, we, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  addr, cyc, stb, we, wdat,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one Wishbone slave bus between the instruction fetcher
// (m0) and the load/store unit (m1). Ownership is round-robin and lasts for
// the whole bus cycle. The owner's request is muxed combinationally onto the
// slave bus. A stalled cycle is aborted after TIMEOUT cycles without ack/err,
// and the owner then sees a one-cycle err.
module wb_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    wb_arbiter_if.slave  m0,
    wb_arbiter_if.slave  m1,
    wb_arbiter_if.master s,
    output logic [1:0]   o_grant,
    output logic         o_timeout
);

    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
    localparam logic [TW-1:0] CNT_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_MAX   = {TW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    // One-hot grant vector for a master index (bit0 = m0).
    function automatic logic [1:0] onehot(input logic m);
        logic [1:0] v;
        if (m) begin
            v = 2'b10;
        end else begin
            v = 2'b01;
        end
        return v;
    endfunction

    state_t        state_r;
    logic          owner_r;     // index of the master holding the bus
    logic          rr_prio_r;   // master favoured at the next contention
    logic [1:0]    grant_r;
    logic [TW-1:0] cnt_r;       // cycles since last ack/err in the current cycle
    logic          timeout_r;

    logic          own_cyc_s;
    logic [31:0]   own_addr_s;
    logic [3:0]    own_stb_s;
    logic          own_we_s;
    logic [31:0]   own_wdat_s;
    logic          other_req_s;
    logic          idle_win_s;
    logic          busy_s;
    logic          abort_s;
    logic          s_resp_s;

    assign busy_s   = (state_r == ST_BUSY);
    assign abort_s  = (state_r == ST_ABORT);
    assign s_resp_s = s.ack | s.err;

    // Select the owner's request lines and the other master's request
    always_comb begin
        if (owner_r) begin
            own_cyc_s   = m1.cyc;
            own_addr_s  = m1.addr;
            own_stb_s   = m1.stb;
            own_we_s    = m1.we;
            own_wdat_s  = m1.wdat;
            other_req_s = m0.cyc;
        end else begin
            own_cyc_s   = m0.cyc;
            own_addr_s  = m0.addr;
            own_stb_s   = m0.stb;
            own_we_s    = m0.we;
            own_wdat_s  = m0.wdat;
            other_req_s = m1.cyc;
        end
    end

    // Winner when leaving IDLE: a lone requester wins, contention goes to rr_prio
    always_comb begin
        if (m0.cyc && m1.cyc) begin
            idle_win_s = rr_prio_r;
        end else if (m1.cyc) begin
            idle_win_s = 1'b1;
        end else begin
            idle_win_s = 1'b0;
        end
    end

    // Ownership FSM with round-robin pointer, timeout counter and registered grant/timeout
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            owner_r   <= 1'b0;
            rr_prio_r <= 1'b0;
            grant_r   <= 2'b00;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (m0.cyc || m1.cyc) begin
                        state_r <= ST_BUSY;
                        owner_r <= idle_win_s;
                        grant_r <= onehot(idle_win_s);
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= 2'b00;
                    end
                end
                ST_BUSY: begin
                    if (!own_cyc_s) begin
                        // Owner released: the other master gets priority and,
                        // if it is already waiting, takes the bus immediately.
                        rr_prio_r <= ~owner_r;
                        cnt_r     <= CNT_ZERO;
                        if (other_req_s) begin
                            state_r <= ST_BUSY;
                            owner_r <= ~owner_r;
                            grant_r <= onehot(~owner_r);
                        end else begin
                            state_r <= ST_IDLE;
                            grant_r <= 2'b00;
                        end
                    end else if (s_resp_s) begin
                        // A response in the boundary cycle still beats the abort.
                        cnt_r <= CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_V) begin
                        state_r   <= ST_ABORT;
                        timeout_r <= 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_ABORT: begin
                    rr_prio_r <= ~owner_r;
                    state_r   <= ST_IDLE;
                    grant_r   <= 2'b00;
                    cnt_r     <= CNT_ZERO;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 2'b00;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Drive the slave bus from the owner only while a cycle is in progress
    always_comb begin
        if (busy_s) begin
            s.cyc  = own_cyc_s;
            s.addr = own_addr_s;
            s.stb  = own_stb_s;
            s.we   = own_we_s;
            s.wdat = own_wdat_s;
        end else begin
            s.cyc  = 1'b0;
            s.addr = 32'h0000_0000;
            s.stb  = 4'b0000;
            s.we   = 1'b0;
            s.wdat = 32'h0000_0000;
        end
    end

    // Steer slave responses to the owner; an abort is reported to it as err
    always_comb begin
        m0.ack = busy_s & grant_r[0] & m0.cyc & s.ack;
        m1.ack = busy_s & grant_r[1] & m1.cyc & s.ack;
        m0.err = grant_r[0] & ((busy_s & m0.cyc & s.err) | abort_s);
        m1.err = grant_r[1] & ((busy_s & m1.cyc & s.err) | abort_s);
    end

    // Read data is broadcast; each master qualifies it with its own ack
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;

    assign o_grant   = grant_r;
    assign o_timeout = timeout_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized rounds of bus accesses from both masters against a
// bench slave. A transaction-level round-robin model predicts the service order
// and each access's outcome; expected responses are queued when stimulus is
// issued and a separate monitor pops them whenever the arbiter forwards one.
module tb_wb_arbiter;

    localparam int TMO    = 4;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       tmo;

    wb_arbiter_if m0_if ();
    wb_arbiter_if m1_if ();
    wb_arbiter_if s_if ();

    wb_arbiter #(.TIMEOUT(TMO), .TW(8)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .o_grant  (grant),
        .o_timeout(tmo)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  stb;
        logic        we;
        logic [31:0] wdat;
        int          lat;
        int          kind;
        logic [31:0] rdat;
    } acc_t;

    typedef struct {
        int          m;
        logic        ack;
        logic        err;
        logic        tmo;
        logic [31:0] rdat;
    } rsp_t;

    rsp_t exp_q[$];
    acc_t plan_q[$];

    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc_no    = 0;
    int   prio      = 0;
    bit   s_busy    = 0;
    bit   s_acked   = 0;
    int   s_cnt     = 0;
    int   exp_start = 0;
    acc_t sa;
    rsp_t mr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic acc_t rand_acc(input int m);
        acc_t a;
        logic [3:0] stb_tab [3];
        int k;
        stb_tab = '{4'b1100, 4'b0011, 4'b1111};
        a.m    = m;
        a.addr = $urandom;
        a.stb  = stb_tab[$urandom_range(0, 2)];
        a.we   = 1'($urandom_range(0, 1));
        a.wdat = $urandom;
        a.lat  = $urandom_range(0, TMO);
        a.rdat = $urandom;
        k = $urandom_range(0, 7);
        if (k <= 3)      a.kind = K_ACK;
        else if (k == 4) a.kind = K_ERR;
        else if (k == 5) a.kind = K_BOTH;
        else             a.kind = K_NONE;
        return a;
    endfunction

    task automatic drive_master(input int m, input bit on, input acc_t a);
        if (m == 0) begin
            m0_if.cyc  = on;
            m0_if.stb  = on ? a.stb  : 4'b0000;
            m0_if.addr = on ? a.addr : 32'h0;
            m0_if.we   = on ? a.we   : 1'b0;
            m0_if.wdat = on ? a.wdat : 32'h0;
        end else begin
            m1_if.cyc  = on;
            m1_if.stb  = on ? a.stb  : 4'b0000;
            m1_if.addr = on ? a.addr : 32'h0;
            m1_if.we   = on ? a.we   : 1'b0;
            m1_if.wdat = on ? a.wdat : 32'h0;
        end
    endtask

    // Bench slave: checks routing when an access starts, answers after the planned latency.
    task automatic slave_step();
        s_if.ack  = 1'b0;
        s_if.err  = 1'b0;
        s_if.rdat = $urandom;
        if (s_if.cyc) begin
            if (!s_busy) begin
                if (plan_q.size() == 0) begin
                    fail_now("slave_unplanned", "o_s_cyc high with no access planned, required low");
                    s_busy  = 1;
                    s_acked = 1;
                end else begin
                    sa      = plan_q.pop_front();
                    s_busy  = 1;
                    s_acked = 0;
                    s_cnt   = 0;
                    check("start_cycle", cyc_no, exp_start);
                    check("route_grant", grant, (sa.m == 0) ? 2'b01 : 2'b10);
                    check("route_addr", s_if.addr, sa.addr);
                    check("route_stb", s_if.stb, sa.stb);
                    check("route_we", s_if.we, sa.we);
                    check("route_wdat", s_if.wdat, sa.wdat);
                end
            end
            if (!s_acked) begin
                if (sa.kind != K_NONE && s_cnt == sa.lat) begin
                    s_if.ack  = (sa.kind == K_ACK) || (sa.kind == K_BOTH);
                    s_if.err  = (sa.kind == K_ERR) || (sa.kind == K_BOTH);
                    s_if.rdat = sa.rdat;
                    s_acked   = 1;
                end
                s_cnt++;
            end
        end else if (s_busy) begin
            if (!s_acked) check("abort_after_cycles", s_cnt, TMO + 1);
            exp_start = cyc_no + (s_acked ? 1 : 2);
            s_busy    = 0;
        end
    endtask

    // Monitor: every forwarded ack/err/timeout must match the next expected response
    always @(negedge clk) begin
        if (m0_if.ack || m0_if.err || m1_if.ack || m1_if.err || tmo) begin
            if (exp_q.size() == 0) begin
                fail_now("rsp_unexpected", $sformatf("ack0=%0b err0=%0b ack1=%0b err1=%0b tmo=%0b, required all 0",
                         m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, tmo));
            end else begin
                mr = exp_q.pop_front();
                check("rsp_m0_ack", m0_if.ack, (mr.m == 0) && mr.ack);
                check("rsp_m0_err", m0_if.err, (mr.m == 0) && mr.err);
                check("rsp_m1_ack", m1_if.ack, (mr.m == 1) && mr.ack);
                check("rsp_m1_err", m1_if.err, (mr.m == 1) && mr.err);
                check("rsp_timeout", tmo, mr.tmo);
                if (mr.ack) begin
                    check("rsp_m0_dat", m0_if.rdat, mr.rdat);
                    check("rsp_m1_dat", m1_if.rdat, mr.rdat);
                end
            end
        end
    end

    // One round: requesting masters raise cyc together from idle, each holds it
    // until its own ack/err and drops it the next cycle.
    task automatic run_round(input logic [1:0] mask, input acc_t a0, input acc_t a1);
        int   order[$];
        rsp_t r;
        acc_t a;
        bit   act[2];
        bit   rel[2];
        int   budget;
        // Reference: contention served from prio; after any access the other master is favoured.
        if (mask == 2'b11) begin
            order.push_back(prio);
            order.push_back(1 - prio);
        end else if (mask == 2'b10) begin
            order.push_back(1);
        end else begin
            order.push_back(0);
        end
        foreach (order[k]) begin
            if (order[k] == 0) a = a0;
            else a = a1;
            plan_q.push_back(a);
            r.m    = a.m;
            r.ack  = (a.kind == K_ACK) || (a.kind == K_BOTH);
            r.err  = (a.kind != K_ACK);
            r.tmo  = (a.kind == K_NONE);
            r.rdat = a.rdat;
            exp_q.push_back(r);
            prio = 1 - a.m;
        end
        @(posedge clk); #1;
        act[0] = mask[0];
        act[1] = mask[1];
        rel[0] = 0;
        rel[1] = 0;
        if (mask[0]) drive_master(0, 1'b1, a0);
        if (mask[1]) drive_master(1, 1'b1, a1);
        exp_start = cyc_no + 1;
        #1; slave_step();
        @(negedge clk);
        if (act[0] && (m0_if.ack || m0_if.err)) rel[0] = 1;
        if (act[1] && (m1_if.ack || m1_if.err)) rel[1] = 1;
        budget = 0;
        while ((act[0] || act[1] || s_busy) && budget < 60) begin
            @(posedge clk); #1;
            if (rel[0]) begin drive_master(0, 1'b0, a0); act[0] = 0; rel[0] = 0; end
            if (rel[1]) begin drive_master(1, 1'b0, a1); act[1] = 0; rel[1] = 0; end
            #1; slave_step();
            @(negedge clk);
            if (act[0] && (m0_if.ack || m0_if.err)) rel[0] = 1;
            if (act[1] && (m1_if.ack || m1_if.err)) rel[1] = 1;
            budget++;
        end
        if (budget >= 60) begin
            fail_now("round_budget", "round still busy after 60 cycles, required completion");
            @(posedge clk); #1;
            drive_master(0, 1'b0, a0);
            drive_master(1, 1'b0, a1);
            s_if.ack = 1'b0;
            s_if.err = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_q.delete();
            plan_q.delete();
            s_busy = 0;
            prio   = 0;
        end
    endtask

    initial begin
        acc_t a0;
        acc_t a1;
        rst = 1'b1;
        a0  = rand_acc(0);
        drive_master(0, 1'b0, a0);
        drive_master(1, 1'b0, a0);
        s_if.ack  = 1'b0;
        s_if.err  = 1'b0;
        s_if.rdat = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_grant", grant, 2'b00);
        check("reset_s_cyc", s_if.cyc, 1'b0);
        check("reset_s_stb", s_if.stb, 4'b0000);
        check("reset_s_we", s_if.we, 1'b0);
        check("reset_s_addr", s_if.addr, 32'h0);
        check("reset_s_dat", s_if.wdat, 32'h0);
        check("reset_rsp", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 4'b0000);
        check("reset_timeout", tmo, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single fetch: upper halfword, acked in the third cycle of ownership.
        a0 = rand_acc(0);
        a0.stb = 4'b1100; a0.we = 1'b0; a0.lat = 2; a0.kind = K_ACK; a0.rdat = 32'h1234_5678;
        run_round(2'b01, a0, rand_acc(1));

        // Write routing from m1 while m0 is idle.
        a1 = rand_acc(1);
        a1.addr = 32'h0000_0100; a1.wdat = 32'hDEAD_BEEF; a1.stb = 4'b0011; a1.we = 1'b1;
        a1.kind = K_ACK; a1.lat = 1;
        run_round(2'b10, rand_acc(0), a1);

        // Timeout on m0, then contention must favour m1.
        a0 = rand_acc(0);
        a0.kind = K_NONE;
        run_round(2'b01, a0, rand_acc(1));
        a0 = rand_acc(0); a0.kind = K_ACK;
        a1 = rand_acc(1); a1.kind = K_ACK;
        run_round(2'b11, a0, a1);

        // Ack exactly on the timeout boundary.
        a0 = rand_acc(0);
        a0.kind = K_ACK; a0.lat = TMO;
        run_round(2'b01, a0, rand_acc(1));

        // Strict alternation under permanent contention.
        for (int i = 0; i < 10; i++) begin
            a0 = rand_acc(0); a0.kind = K_ACK;
            a1 = rand_acc(1); a1.kind = K_ACK;
            run_round(2'b11, a0, a1);
        end

        // Random mix of requesters, latencies and outcomes.
        for (int i = 0; i < 40; i++) begin
            run_round(2'($urandom_range(1, 3)), rand_acc(0), rand_acc(1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset while m1 owns a stalled cycle; a late ack must not be forwarded.
        a1 = rand_acc(1);
        a1.stb = 4'b1111;
        @(posedge clk); #1;
        drive_master(1, 1'b1, a1);
        s_if.ack = 1'b0;
        s_if.err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_pre_grant", grant, 2'b10);
        check("rstmid_pre_s_cyc", s_if.cyc, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        s_if.ack = 1'b1;
        @(negedge clk);
        check("rstmid_grant", grant, 2'b00);
        check("rstmid_s_cyc", s_if.cyc, 1'b0);
        check("rstmid_s_stb", s_if.stb, 4'b0000);
        check("rstmid_m1_ack", m1_if.ack, 1'b0);
        @(posedge clk); #1;
        s_if.ack = 1'b0;
        drive_master(1, 1'b0, a1);
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("exp_q_empty", exp_q.size(), 0);
        check("plan_q_empty", plan_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
